// File: rtl/mips_defines.sv
// Shared definitions for the execute-stage divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_defines;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage; quotient->LO, remainder->HI.
// Latency: divide seen in cycle T, result valid in T+DW+1 (T+1 on the early-out path).
// Backpressure: raises div_stallE while dividing; holds the DONE result while ext_stall freezes the pipe.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   div_validE, div_signedE   divide present in E / signed (DIV) vs unsigned (DIVU)
//   srcaE, srcbE              dividend / divisor
//   ext_stall, flushE         pipe frozen elsewhere / exception flush of E
//   div_stallE                stall request to the hazard unit
//   div_resvalidE             {hi,lo} valid for the E instruction
//   div_resultE               {remainder, quotient}
//
// Build option: define DIV_EARLY_OUT_EN to finish in one cycle when |b|==0 or |a|<|b|.
module div_unit
    import mips_defines::*;
#(
    parameter int DW = DIV_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_validE,
    input  logic            div_signedE,
    input  logic [DW-1:0]   srcaE,
    input  logic [DW-1:0]   srcbE,
    input  logic            ext_stall,
    input  logic            flushE,
    output logic            div_stallE,
    output logic            div_resvalidE,
    output logic [2*DW-1:0] div_resultE
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_t    r_state;
    div_state_t    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_a;        // dividend shifting out at the top, quotient bits shifting in at the bottom
    logic [DW-1:0] r_b;        // |divisor|
    logic [DW-1:0] r_rem;      // partial remainder
    logic          r_sign_q;
    logic          r_sign_r;

    logic          w_sa;
    logic          w_sb;
    logic [DW-1:0] w_abs_a;
    logic [DW-1:0] w_abs_b;
    logic          w_start;
    logic          w_early;
    logic [DW:0]   w_rem_sh;
    logic          w_ge;
    logic [DW-1:0] w_rem_nxt;
    logic          w_last;
    logic          w_dvz;
    logic [DW-1:0] w_q_fix;
    logic [DW-1:0] w_r_fix;

    // Operand magnitudes; signs are forced to 0 for DIVU.
    assign w_sa    = div_signedE & srcaE[DW-1];
    assign w_sb    = div_signedE & srcbE[DW-1];
    assign w_abs_a = w_sa ? (~srcaE + DW'(1)) : srcaE;
    assign w_abs_b = w_sb ? (~srcbE + DW'(1)) : srcbE;

    assign w_start = (r_state == IDLE) & div_validE & ~flushE;

`ifdef DIV_EARLY_OUT_EN
    // Quotient is trivially 0 (or the divide-by-zero pattern) - skip the iterations.
    assign w_early = (w_abs_b == '0) | (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step. The shifted remainder needs DW+1 bits because
    // rem < |b| can be as large as 2^DW-1 before the shift.
    assign w_rem_sh  = {r_rem, r_a[DW-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_nxt = w_ge ? (w_rem_sh[DW-1:0] - r_b) : w_rem_sh[DW-1:0];
    assign w_last    = (r_count == CW'(DW-1));

    // Next-state logic; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (flushE) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (div_validE) w_state_nxt = w_early ? DONE : BUSY;
                BUSY:    if (w_last)     w_state_nxt = DONE;
                DONE:    if (!ext_stall) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    // Every field is reloaded on accept, so an aborted divide leaves nothing behind.
                    if (w_start) begin
                        r_b      <= w_abs_b;
                        r_sign_q <= w_sa ^ w_sb;
                        r_sign_r <= w_sa;
                        r_count  <= '0;
                        if (w_early) begin
                            r_a   <= '0;
                            r_rem <= w_abs_a;
                        end else begin
                            r_a   <= w_abs_a;
                            r_rem <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (!flushE) begin
                        r_rem   <= w_rem_nxt;
                        r_a     <= {r_a[DW-2:0], w_ge};
                        r_count <= w_last ? '0 : (r_count + CW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Divide by zero: lo is all ones regardless of sign mode. The remainder
    // register then holds |a|, and restoring its sign reproduces srcaE exactly
    // (including 0x80000000), which is the required hi value.
    assign w_dvz   = (r_b == '0);
    assign w_q_fix = w_dvz ? {DW{1'b1}} : (r_sign_q ? (~r_a + DW'(1)) : r_a);
    assign w_r_fix = r_sign_r ? (~r_rem + DW'(1)) : r_rem;

    assign div_stallE    = ~flushE & (((r_state == IDLE) & div_validE) | (r_state == BUSY));
    assign div_resvalidE = (r_state == DONE);
    assign div_resultE   = (r_state == DONE) ? {w_r_fix, w_q_fix} : '0;

endmodule
